// File: rtl/j_uart3.sv
// j_uart3: CPU-attached UART with a prescaled 16x baud tick, TX/RX FIFOs,
// optional parity, sticky error flags and a level interrupt.
module j_uart3 #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PSCL_W     = 16
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic [15:0] din,
  input  logic        u2psclw,
  input  logic        u2psclr,
  input  logic        u2drd,
  input  logic        u2dwr,
  input  logic        u2strd,
  input  logic        u2ctwr,
  input  logic        serin,
  output logic        serout,
  output logic        uint,
  output logic [15:0] dr_out,
  output logic        dr_oe
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRK} rx_state_t;

  logic [PSCL_W-1:0] pscl, pcnt;
  logic [4:0]        ctrl;
  logic              tick, perr, ferr, ovr, err_clr;
  logic [15:0]       status;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wptr, tx_rptr;
  logic [AW:0]       tx_count;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  tx_state_t         tx_state;
  logic [3:0]        tx_tcnt;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_par, tx_line;

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     rx_wptr, rx_rptr;
  logic [AW:0]       rx_count;
  logic              rx_push, rx_pop, rx_wr, rx_full, rx_empty;
  rx_state_t         rx_state;
  logic [3:0]        rx_cnt;
  logic [BW-1:0]     rx_bit;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_par_bad, rx_s;
  logic [1:0]        sync;

  assign tick     = (pcnt == pscl);
  assign err_clr  = u2ctwr & din[5];
  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign tx_push  = u2dwr & ~tx_full;
  assign tx_pop   = tick & ~tx_empty &
                    ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tcnt == 4'hF));
  assign rx_s     = sync[1];
  assign rx_push  = tick & (rx_state == RX_STOP) & (rx_cnt == 4'hF);
  assign rx_pop   = u2drd & ~rx_empty;
  assign rx_wr    = rx_push & (~rx_full | rx_pop);
  assign serout   = tx_line & ~ctrl[4];
  assign dr_oe    = u2drd | u2strd | u2psclr;
  assign status   = {9'd0, rx_full, tx_empty & (tx_state == TX_IDLE), ovr, ferr, perr,
                     ~tx_full, ~rx_empty};

  always_comb begin
    dr_out = '0;
    if (u2drd) begin
      if (!rx_empty) dr_out = 16'(rx_mem[rx_rptr]);
    end else if (u2strd) begin
      dr_out = status;
    end else if (u2psclr) begin
      dr_out = 16'(pscl);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      pscl <= '0;
      pcnt <= '0;
      ctrl <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      ovr  <= 1'b0;
      uint <= 1'b0;
    end else begin
      if (u2psclw) begin
        pscl <= din[PSCL_W-1:0];
        pcnt <= '0;
      end else if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (u2ctwr) ctrl <= din[4:0];
      // Error sets beat a concurrent clear so no event is ever lost.
      if (rx_push && rx_par_bad) perr <= 1'b1;
      else if (err_clr)          perr <= 1'b0;
      if (rx_push && !rx_s)      ferr <= 1'b1;
      else if (err_clr)          ferr <= 1'b0;
      if (rx_push && rx_full && !rx_pop) ovr <= 1'b1;
      else if (err_clr)                  ovr <= 1'b0;
      uint <= (ctrl[2] & (~rx_empty | perr | ferr | ovr)) | (ctrl[3] & tx_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= din[DATA_W-1:0];
    if (rx_wr)   rx_mem[rx_wptr] <= rx_sh;
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (rx_wr)  rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
      if (rx_wr && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_wr && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // Transmitter: a pop always lands in START, whether from IDLE or from STOP.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_tcnt  <= '0;
      tx_sh    <= tx_mem[tx_rptr];
      tx_par   <= (^tx_mem[tx_rptr]) ^ ctrl[0];
      tx_line  <= 1'b0;
    end else if (tick && tx_state != TX_IDLE) begin
      tx_tcnt <= tx_tcnt + 1'b1;
      if (tx_tcnt == 4'hF) begin
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx_line  <= tx_sh[0];
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
              tx_state <= ctrl[1] ? TX_PARITY : TX_STOP;
              tx_line  <= ctrl[1] ? tx_par : 1'b1;
            end else begin
              tx_bit  <= tx_bit + 1'b1;
              tx_sh   <= tx_sh >> 1;
              tx_line <= tx_sh[1];
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            tx_line  <= 1'b1;
          end
          default: begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Receiver: the start bit is checked at its midpoint, later bits 16 ticks apart.
  always_ff @(posedge clk) begin
    if (!resetl) begin
      sync       <= 2'b11;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      sync <= {sync[0], serin};
      case (rx_state)
        RX_IDLE: if (!rx_s) begin
          rx_state   <= RX_START;
          rx_cnt     <= '0;
          rx_par_bad <= 1'b0;
        end
        RX_START: if (tick) begin
          if (rx_cnt == 4'd7) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: if (tick) begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == 4'hF) begin
            rx_sh  <= {rx_s, rx_sh[DATA_W-1:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == LAST_BIT) rx_state <= ctrl[1] ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (tick) begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == 4'hF) begin
            rx_par_bad <= ((^rx_sh) ^ ctrl[0]) != rx_s;
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          rx_cnt <= rx_cnt + 1'b1;
          if (rx_cnt == 4'hF) rx_state <= rx_s ? RX_IDLE : RX_BRK;
        end
        default: if (rx_s) rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_j_uart3.sv
// Scoreboard bench for j_uart3: read-bus and serial-frame monitors check
// against expectations queued by directed stimulus.
module tb_j_uart3;
  logic        clk = 1'b0;
  logic        resetl;
  logic [15:0] din;
  logic        u2psclw, u2psclr, u2drd, u2dwr, u2strd, u2ctwr;
  logic        serin, serin_drv, loopback;
  logic        serout, uint, dr_oe;
  logic [15:0] dr_out;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          bit_clks = 16;
  logic        par_en = 1'b0;
  logic        tx_mon_en = 1'b0;
  logic [15:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic [7:0]  tx_exp_q[$];
  logic        tx_par_q[$];
  int          frame_starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign serin = loopback ? serout : serin_drv;

  j_uart3 dut (
    .clk(clk), .resetl(resetl), .din(din),
    .u2psclw(u2psclw), .u2psclr(u2psclr), .u2drd(u2drd), .u2dwr(u2dwr),
    .u2strd(u2strd), .u2ctwr(u2ctwr), .serin(serin), .serout(serout),
    .uint(uint), .dr_out(dr_out), .dr_oe(dr_oe)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string op, input logic [15:0] d, input logic [15:0] e);
    din = d;
    if (op == "pscl_wr") u2psclw = 1'b1;
    else if (op == "ctrl_wr") u2ctwr = 1'b1;
    else if (op == "data_wr") u2dwr = 1'b1;
    else begin
      rd_exp_q.push_back(e);
      rd_name_q.push_back(op);
      if (op == "pscl_rd") u2psclr = 1'b1;
      else if (op == "data_rd") u2drd = 1'b1;
      else u2strd = 1'b1;
    end
    wait_clks(1);
    {u2psclw, u2psclr, u2drd, u2dwr, u2strd, u2ctwr} = '0;
    din = '0;
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic p);
    tx_exp_q.push_back(d);
    tx_par_q.push_back(p);
  endtask

  task automatic send_serial(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
    serin_drv = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      serin_drv = d[i];
      wait_clks(bit_clks);
    end
    if (pe) begin
      serin_drv = pb;
      wait_clks(bit_clks);
    end
    serin_drv = sb;
    wait_clks(bit_clks);
    serin_drv = 1'b1;
    wait_clks(bit_clks);
  endtask

  // Read-bus monitor: every driven read consumes one queued expectation.
  always @(negedge clk) begin
    if (dr_oe) begin
      if (rd_exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_read: got 0x%04h, expected no read", dr_out);
      end else begin
        checkOutput(rd_name_q.pop_front(), dr_out, rd_exp_q.pop_front());
      end
    end
  end

  // Serial monitor: decodes frames on serout at the current bit time.
  initial begin : tx_mon
    logic [7:0] d;
    logic       pb, sb, ep;
    int         st;
    forever begin
      @(negedge clk);
      if (serout === 1'b0) begin
        st = cyc;
        repeat (bit_clks / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          d[i] = serout;
        end
        pb = 1'b0;
        if (par_en) begin
          repeat (bit_clks) @(negedge clk);
          pb = serout;
        end
        repeat (bit_clks) @(negedge clk);
        sb = serout;
        if (tx_mon_en) begin
          frame_starts.push_back(st);
          if (tx_exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_frame: got 0x%02h, expected no frame", d);
          end else begin
            ep = tx_par_q.pop_front();
            checkOutput("tx_data", {8'h00, d}, {8'h00, tx_exp_q.pop_front()});
            if (par_en) checkOutput("tx_parity", {15'd0, pb}, {15'd0, ep});
            checkOutput("tx_stop", {15'd0, sb}, 16'h0001);
          end
        end
      end
    end
  end

  initial begin
    resetl = 1'b0;
    din = '0;
    {u2psclw, u2psclr, u2drd, u2dwr, u2strd, u2ctwr} = '0;
    serin_drv = 1'b1;
    loopback = 1'b0;
    wait_clks(5);
    resetl = 1'b1;

    // Reset state
    checkOutput("reset_serout", {15'd0, serout}, 16'h0001);
    checkOutput("reset_uint", {15'd0, uint}, 16'h0000);
    applyStimulus("stat_rd", 0, 16'h0022);
    applyStimulus("pscl_rd", 0, 16'h0000);
    wait_clks(200);
    tx_mon_en = 1'b1;

    // Loopback of 0x55 at pscl=0
    loopback = 1'b1;
    expect_tx(8'h55, 1'b0);
    applyStimulus("data_wr", 16'h0055, 0);
    wait_clks(200);
    applyStimulus("stat_rd", 0, 16'h0023);
    applyStimulus("data_rd", 0, 16'h0055);
    applyStimulus("stat_rd", 0, 16'h0022);
    applyStimulus("data_rd", 0, 16'h0000);
    applyStimulus("pscl_wr", 16'h1234, 0);
    applyStimulus("pscl_rd", 0, 16'h1234);
    applyStimulus("pscl_wr", 16'h0000, 0);

    // Odd parity, two back-to-back frames of 0x07
    applyStimulus("ctrl_wr", 16'h0003, 0);
    par_en = 1'b1;
    frame_starts.delete();
    expect_tx(8'h07, 1'b0);
    expect_tx(8'h07, 1'b0);
    applyStimulus("data_wr", 16'h0007, 0);
    applyStimulus("data_wr", 16'h0007, 0);
    wait_clks(450);
    checkOutput("par_frames", 16'(frame_starts.size()), 16'd2);
    if (frame_starts.size() == 2)
      checkOutput("par_frame_gap", 16'(frame_starts[1] - frame_starts[0]), 16'd176);
    applyStimulus("stat_rd", 0, 16'h0023);
    applyStimulus("data_rd", 0, 16'h0007);
    applyStimulus("data_rd", 0, 16'h0007);
    applyStimulus("stat_rd", 0, 16'h0022);
    loopback = 1'b0;
    send_serial(8'h07, 1'b1, 1'b1, 1'b1);
    wait_clks(20);
    applyStimulus("stat_rd", 0, 16'h0027);
    applyStimulus("data_rd", 0, 16'h0007);
    applyStimulus("stat_rd", 0, 16'h0026);
    applyStimulus("ctrl_wr", 16'h0023, 0);
    applyStimulus("stat_rd", 0, 16'h0022);

    // RX overrun with FIFO_DEPTH+1 words
    applyStimulus("ctrl_wr", 16'h0000, 0);
    par_en = 1'b0;
    send_serial(8'h11, 1'b0, 1'b0, 1'b1);
    send_serial(8'h22, 1'b0, 1'b0, 1'b1);
    send_serial(8'h33, 1'b0, 1'b0, 1'b1);
    send_serial(8'h44, 1'b0, 1'b0, 1'b1);
    send_serial(8'h55, 1'b0, 1'b0, 1'b1);
    applyStimulus("stat_rd", 0, 16'h0073);
    applyStimulus("data_rd", 0, 16'h0011);
    applyStimulus("data_rd", 0, 16'h0022);
    applyStimulus("data_rd", 0, 16'h0033);
    applyStimulus("data_rd", 0, 16'h0044);
    applyStimulus("stat_rd", 0, 16'h0032);
    applyStimulus("ctrl_wr", 16'h0020, 0);
    applyStimulus("stat_rd", 0, 16'h0022);

    // Framing error: zero stop bit
    send_serial(8'h81, 1'b0, 1'b0, 1'b0);
    wait_clks(20);
    applyStimulus("stat_rd", 0, 16'h002B);
    applyStimulus("data_rd", 0, 16'h0081);
    applyStimulus("ctrl_wr", 16'h0020, 0);
    applyStimulus("stat_rd", 0, 16'h0022);

    // Interrupt enables
    applyStimulus("ctrl_wr", 16'h0004, 0);
    wait_clks(2);
    checkOutput("uint_rx_empty", {15'd0, uint}, 16'h0000);
    send_serial(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_clks(20);
    checkOutput("uint_rx_data", {15'd0, uint}, 16'h0001);
    applyStimulus("data_rd", 0, 16'h003C);
    wait_clks(2);
    checkOutput("uint_rx_drained", {15'd0, uint}, 16'h0000);
    applyStimulus("ctrl_wr", 16'h0008, 0);
    wait_clks(2);
    checkOutput("uint_tx_empty", {15'd0, uint}, 16'h0001);
    applyStimulus("ctrl_wr", 16'h0000, 0);
    wait_clks(2);
    checkOutput("uint_off", {15'd0, uint}, 16'h0000);

    // Five writes into a 4-deep TX FIFO before the first tick
    applyStimulus("pscl_wr", 16'h0007, 0);
    bit_clks = 128;
    frame_starts.delete();
    expect_tx(8'hA1, 1'b0);
    expect_tx(8'hA2, 1'b0);
    expect_tx(8'hA3, 1'b0);
    expect_tx(8'hA4, 1'b0);
    applyStimulus("data_wr", 16'h00A1, 0);
    applyStimulus("data_wr", 16'h00A2, 0);
    applyStimulus("data_wr", 16'h00A3, 0);
    applyStimulus("data_wr", 16'h00A4, 0);
    applyStimulus("data_wr", 16'h00A5, 0);
    applyStimulus("stat_rd", 0, 16'h0000);
    wait_clks(4 * 1280 + 400);
    checkOutput("burst_frames", 16'(frame_starts.size()), 16'd4);
    for (int i = 1; i < frame_starts.size(); i++)
      checkOutput("burst_gap", 16'(frame_starts[i] - frame_starts[i-1]), 16'd1280);
    applyStimulus("stat_rd", 0, 16'h0022);

    // Start-bit glitch at pscl=3, then a clean frame
    applyStimulus("pscl_wr", 16'h0003, 0);
    bit_clks = 64;
    serin_drv = 1'b0;
    wait_clks(4);
    serin_drv = 1'b1;
    wait_clks(200);
    applyStimulus("stat_rd", 0, 16'h0022);
    send_serial(8'h5A, 1'b0, 1'b0, 1'b1);
    wait_clks(40);
    applyStimulus("stat_rd", 0, 16'h0023);
    applyStimulus("data_rd", 0, 16'h005A);
    applyStimulus("stat_rd", 0, 16'h0022);

    // Break, then reset in the middle of a loopback frame
    applyStimulus("pscl_wr", 16'h0000, 0);
    bit_clks = 16;
    tx_mon_en = 1'b0;
    applyStimulus("ctrl_wr", 16'h0010, 0);
    checkOutput("break_serout", {15'd0, serout}, 16'h0000);
    applyStimulus("ctrl_wr", 16'h0000, 0);
    wait_clks(300);
    loopback = 1'b1;
    applyStimulus("ctrl_wr", 16'h0008, 0);
    applyStimulus("data_wr", 16'h003C, 0);
    wait_clks(50);
    checkOutput("uint_pre_reset", {15'd0, uint}, 16'h0001);
    resetl = 1'b0;
    wait_clks(1);
    resetl = 1'b1;
    checkOutput("rst_serout", {15'd0, serout}, 16'h0001);
    checkOutput("rst_uint", {15'd0, uint}, 16'h0000);
    applyStimulus("stat_rd", 0, 16'h0022);
    wait_clks(300);
    applyStimulus("stat_rd", 0, 16'h0022);
    applyStimulus("pscl_rd", 0, 16'h0000);

    wait_clks(5);
    checkOutput("reads_outstanding", 16'(rd_exp_q.size()), 16'd0);
    checkOutput("frames_outstanding", 16'(tx_exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
